// File: rtl/alu_result_buffer.sv
// ALU result buffer: captures result bytes with carry, zero and neg flags
// and presents them first-word-fall-through with occupancy statistics.
module alu_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    peak,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_e;

  typedef struct packed {
    logic             carry;
    logic             neg;
    logic             zero;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          wr_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [CW-1:0]   peak_q;
  logic [7:0]      drop_q;
  occ_e            state_q;
  occ_e            state_d;
  logic            push;
  logic            pop;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry.carry = in_carry;
  assign wr_entry.neg   = in_data[WIDTH-1];
  assign wr_entry.zero  = (in_data == '0);
  assign wr_entry.data  = in_data;

  // Gate with out_valid so the outputs read 0 while empty or in reset.
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = head.data;
  assign out_zero  = head.zero;
  assign out_neg   = head.neg;
  assign out_carry = head.carry;

  assign count    = count_q;
  assign peak     = peak_q;
  assign drop_cnt = drop_q;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      clear:                    count_d = '0;
      !clear && push && !pop:   count_d = count_q + CW'(1);
      !clear && !push && pop:   count_d = count_q - CW'(1);
      default:                  count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = PARTIAL;
    if (count_d == '0)
      state_d = EMPTY;
    else if (count_d == CW'(DEPTH))
      state_d = FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
      drop_q <= '0;
    end else if (clear) begin
      peak_q <= '0;
      drop_q <= '0;
    end else begin
      if (count_d > peak_q) peak_q <= count_d;
      if (in_valid && !in_ready && drop_q != 8'hff)
        drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          in_carry = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_zero;
  logic          out_neg;
  logic          out_carry;
  logic [CW-1:0] count;
  logic [CW-1:0] peak;
  logic [7:0]    drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic       carry;
  } item_t;

  item_t q[$];
  int    m_peak = 0;
  int    m_drop = 0;

  alu_result_buffer #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero),
    .out_neg(out_neg), .out_carry(out_carry),
    .count(count), .peak(peak), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Drives one cycle starting just after an edge, advances the model
  // across the edge, and returns 1 time unit after it.
  task automatic drive(input logic v, input logic [7:0] d,
                       input logic c, input logic r, input logic cl);
    bit pu;
    bit po;
    item_t it;
    in_valid = v;
    in_data = d;
    in_carry = c;
    out_ready = r;
    clear = cl;
    @(posedge clk);
    if (cl) begin
      q.delete();
      m_peak = 0;
      m_drop = 0;
    end else begin
      pu = v && (q.size() < DEPTH);
      po = r && (q.size() > 0);
      if (v && q.size() == DEPTH && m_drop < 255) m_drop++;
      if (po) void'(q.pop_front());
      if (pu) begin
        it.data = d;
        it.carry = c;
        q.push_back(it);
      end
      if (q.size() > m_peak) m_peak = q.size();
    end
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (count !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (peak !== 0 || drop_cnt !== 0) begin errors++; $display("FAIL reset_stats: got peak=%0d drop=%0d want 0 0", peak, drop_cnt); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    q.delete();
    m_peak = 0;
    m_drop = 0;
    drive(0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_pass_through;
    drive(1, 8'h05, 0, 1, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pt_valid: got %b want 1", out_valid); end
    checks++; if ({out_data, out_zero, out_neg, out_carry} !== {8'h05, 3'b000}) begin
      errors++; $display("FAIL pt_head: got %h z%b n%b c%b want 05 z0 n0 c0", out_data, out_zero, out_neg, out_carry);
    end
    drive(0, 8'h00, 0, 1, 0);
    checks++; if (count !== 0) begin errors++; $display("FAIL pt_count: got %0d want 0", count); end
  endtask

  task automatic test_flags;
    logic [7:0] d [3] = '{8'h00, 8'h85, 8'h14};
    logic [2:0] f [3] = '{3'b101, 3'b010, 3'b000};
    logic       c [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) drive(1, d[i], c[i], 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({out_valid, out_data, out_zero, out_neg, out_carry} !== {1'b1, d[i], f[i]}) begin
        errors++; $display("FAIL flags_%0d: got v%b %h z%b n%b c%b want v1 %h zn c=%b", i, out_valid, out_data, out_zero, out_neg, out_carry, d[i], f[i]);
      end
      drive(0, 8'h00, 0, 1, 0);
    end
  endtask

  task automatic test_fill;
    logic [7:0] d [4] = '{8'h04, 8'h14, 8'h85, 8'h81};
    drive(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, d[i], 0, 0, 0);
    checks++; if (count !== 4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got count=%0d rdy=%b want 4 0", count, in_ready); end
    checks++; if (peak !== 4) begin errors++; $display("FAIL fill_peak: got %0d want 4", peak); end
    for (int i = 0; i < 3; i++) drive(1, 8'hee, 0, 0, 0);
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL fill_drop: got %0d want 3", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== d[i] || out_valid !== 1'b1) begin errors++; $display("FAIL drain_%0d: got v%b %h want v1 %h", i, out_valid, out_data, d[i]); end
      drive(0, 8'h00, 0, 1, 0);
    end
    checks++; if (count !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got count=%0d v%b want 0 0", count, out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d [4] = '{8'h95, 8'h90, 8'h91, 8'h94};
    drive(0, 8'h00, 0, 0, 1);
    drive(1, d[0], 0, 0, 0);
    drive(1, d[1], 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_data !== d[i % 4]) begin errors++; $display("FAIL b2b_data_%0d: got %h want %h", i, out_data, d[i % 4]); end
      drive(1, d[(i + 2) % 4], 0, 1, 0);
      checks++; if (count !== 2) begin errors++; $display("FAIL b2b_count_%0d: got %0d want 2", i, count); end
    end
    for (int i = 10; i < 12; i++) begin
      checks++; if (out_data !== d[i % 4]) begin errors++; $display("FAIL b2b_tail_%0d: got %h want %h", i, out_data, d[i % 4]); end
      drive(0, 8'h00, 0, 1, 0);
    end
  endtask

  task automatic test_clear_reset;
    drive(1, 8'h11, 0, 0, 0);
    drive(1, 8'h12, 0, 0, 0);
    drive(1, 8'h13, 0, 0, 0);
    drive(1, 8'h91, 0, 0, 1);
    checks++; if (count !== 0 || peak !== 0) begin errors++; $display("FAIL clr_stats: got count=%0d peak=%0d want 0 0", count, peak); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_hs: got rdy=%b v=%b want 1 0", in_ready, out_valid); end
    drive(1, 8'h22, 0, 0, 0);
    checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL clr_nostore: got %h want 22", out_data); end
    drive(1, 8'h23, 0, 0, 0);
    checks++; if (count !== 2) begin errors++; $display("FAIL clr_refill: got %0d want 2", count); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 0 || out_data !== 8'h00) begin
      errors++; $display("FAIL async_rst: got v%b count=%0d %h want 0 0 00", out_valid, count, out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_peak = 0;
    m_drop = 0;
  endtask

  task automatic test_drop_sat;
    drive(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 8'h40 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 260; i++) drive(1, 8'h77, 0, 0, 0);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_random;
    logic [7:0] d;
    item_t h;
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      drive(1'($urandom_range(0, 2) != 0), d, 1'($urandom),
            1'($urandom_range(0, 2) != 0), $urandom_range(0, 40) == 0);
      checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL rnd_count_%0d: got %0d want %0d", i, count, q.size()); end
      checks++; if (in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_hs_%0d: got rdy=%b v=%b size=%0d", i, in_ready, out_valid, q.size());
      end
      checks++; if (peak !== CW'(m_peak) || drop_cnt !== 8'(m_drop)) begin
        errors++; $display("FAIL rnd_stats_%0d: got peak=%0d drop=%0d want %0d %0d", i, peak, drop_cnt, m_peak, m_drop);
      end
      if (q.size() != 0) begin
        h = q[0];
        checks++; if ({out_data, out_zero, out_neg, out_carry} !== {h.data, h.data == 8'h00, h.data[7], h.carry}) begin
          errors++; $display("FAIL rnd_head_%0d: got %h z%b n%b c%b want %h c%b", i, out_data, out_zero, out_neg, out_carry, h.data, h.carry);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_flags();
    test_fill();
    test_back_to_back();
    test_clear_reset();
    test_drop_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
